// File: rtl/rf_wb_arbiter_if.sv
// Write-back request bundle between the two requesters (ALU = 0, load unit = 1)
// and rf_wb_arbiter. Lane i of each vector belongs to requester i.
interface rf_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 3
);
    logic [1:0]      req_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_data;
    logic [1:0]      req_ready;

    // Requester side: presents writes, receives grants.
    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    // Arbiter side: samples writes, issues grants.
    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between two write-back
// requesters and keeps a per-register pending-write (busy) scoreboard.
// Optional feature macro: RF_WB_FIXED_PRIO_EN -- when defined, requester 0
// always wins a tie; otherwise ties alternate round-robin via `last`.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 3
) (
    input  logic                 clk,
    input  logic                 n_rst,
    rf_wb_arbiter_if.slave       req,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic [AW-1:0]        wa,
    output logic [DW-1:0]        wd,
    output logic                 we,
    output logic [(2**AW)-1:0]   busy,
    output logic [15:0]          stall_cnt
);

    localparam int NREG = 2**AW;

    logic [1:0]      grant;
    logic            gnt_any;
    logic            gnt_sel;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_data;
    logic            stall;

    logic            we_d,        we_q;
    logic [AW-1:0]   wa_d,        wa_q;
    logic [DW-1:0]   wd_d,        wd_q;
    logic [NREG-1:0] busy_d,      busy_q;
    logic [15:0]     stall_cnt_d, stall_cnt_q;
`ifndef RF_WB_FIXED_PRIO_EN
    logic            last_d,      last_q;
`endif

    // Zero-cycle grant; nothing is granted while reset is asserted.
    always_comb begin
        grant = 2'b00;
        if (n_rst) begin
            case (req.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
`ifdef RF_WB_FIXED_PRIO_EN
                2'b11:   grant = 2'b01;
`else
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
`endif
                default: grant = 2'b00;
            endcase
        end
    end

    assign req.req_ready = grant;
    assign gnt_any       = |grant;
    assign gnt_sel       = grant[1];
    assign gnt_addr      = gnt_sel ? req.req_addr[AW +: AW] : req.req_addr[0 +: AW];
    assign gnt_data      = gnt_sel ? req.req_data[DW +: DW] : req.req_data[0 +: DW];
    assign stall         = |(req.req_valid & ~grant);

    // Next-state: write port load/hold, scoreboard update (set beats clear), stall counter.
    always_comb begin
        we_d = gnt_any;
        wa_d = gnt_any ? gnt_addr : wa_q;
        wd_d = gnt_any ? gnt_data : wd_q;

        busy_d = busy_q;
        if (gnt_any)
            busy_d[gnt_addr] = 1'b0;
        if (rsv_valid)
            busy_d[rsv_addr] = 1'b1;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
`ifndef RF_WB_FIXED_PRIO_EN
        last_d = gnt_any ? gnt_sel : last_q;
`endif
    end

    // State registers; last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            we_q        <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
            busy_q      <= '0;
            stall_cnt_q <= '0;
`ifndef RF_WB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            we_q        <= we_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
`ifndef RF_WB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign we        = we_q;
    assign wa        = wa_q;
    assign wd        = wd_q;
    assign busy      = busy_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected register-file writes are queued at
// grant time and popped by an independent monitor whenever we is high.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        rsv_valid;
    logic [2:0]  rsv_addr;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic [7:0]  busy;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    rf_wb_arbiter_if #(.DW(32), .AW(3)) bus ();

    rf_wb_arbiter #(.DW(32), .AW(3)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .req       (bus),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .wa        (wa),
        .wd        (wd),
        .we        (we),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: every write on the register-file port must match the oldest queued grant.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual wa=%0d wd=%h required=no write", wa, wd);
            end else begin
                e = exp_q.pop_front();
                if (wa !== e.a || wd !== e.d) begin
                    errors++;
                    $display("FAIL write actual wa=%0d wd=%h required wa=%0d wd=%h", wa, wd, e.a, e.d);
                end
            end
        end
    end

    // One clock cycle of stimulus; checks the combinational grant and queues the expected write.
    task automatic cyc(input logic nr, input logic [1:0] v,
                       input logic [2:0] a0, input logic [31:0] d0,
                       input logic [2:0] a1, input logic [31:0] d1,
                       input logic rv, input logic [2:0] ra,
                       input logic [1:0] exp_rdy, input string nm);
        wr_t e;
        @(posedge clk);
        #1;
        n_rst         = nr;
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        bus.req_data  = {d1, d0};
        rsv_valid     = rv;
        rsv_addr      = ra;
        @(negedge clk);
        chk(nm, {30'd0, bus.req_ready}, {30'd0, exp_rdy});
        #1;
        if (exp_rdy == 2'b01) begin
            e.a = a0; e.d = d0; exp_q.push_back(e);
        end else if (exp_rdy == 2'b10) begin
            e.a = a1; e.d = d1; exp_q.push_back(e);
        end
    endtask

    task automatic idle(input string nm);
        cyc(1'b1, 2'b00, 3'd0, 32'd0, 3'd0, 32'd0, 1'b0, 3'd0, 2'b00, nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] tie_b;
        logic [1:0] g;
`ifdef RF_WB_FIXED_PRIO_EN
        tie_b = 2'b01;
`else
        tie_b = 2'b10;
`endif
        n_rst         = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_addr  = {3'd2, 3'd1};
        bus.req_data  = {32'hB, 32'hA};
        rsv_valid     = 1'b0;
        rsv_addr      = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {30'd0, bus.req_ready}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_busy", {24'd0, busy}, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);

        // Tie for four cycles: 0,1,0,1 round-robin (0,0,0,0 fixed priority).
        cyc(1'b1, 2'b11, 3'd1, 32'hA, 3'd2, 32'hB, 1'b0, 3'd0, 2'b01, "tie0");
        cyc(1'b1, 2'b11, 3'd1, 32'hA, 3'd2, 32'hB, 1'b0, 3'd0, tie_b, "tie1");
        cyc(1'b1, 2'b11, 3'd1, 32'hA, 3'd2, 32'hB, 1'b0, 3'd0, 2'b01, "tie2");
        cyc(1'b1, 2'b11, 3'd1, 32'hA, 3'd2, 32'hB, 1'b0, 3'd0, tie_b, "tie3");
        idle("tie_idle");
        chk("tie_stall_cnt", {16'd0, stall_cnt}, 32'd4);

        // Single writer, write to a non-busy register.
        cyc(1'b1, 2'b01, 3'd3, 32'h12345678, 3'd0, 32'd0, 1'b0, 3'd0, 2'b01, "single");
        idle("single_n1");
        chk("single_we", {31'd0, we}, 32'd1);
        chk("single_wa", {29'd0, wa}, 32'd3);
        chk("single_wd", wd, 32'h12345678);
        idle("single_n2");
        chk("single_we_off", {31'd0, we}, 32'd0);
        chk("single_wa_hold", {29'd0, wa}, 32'd3);
        chk("single_busy", {24'd0, busy}, 32'd0);

        // Scoreboard set, then clear by req1.
        cyc(1'b1, 2'b00, 3'd0, 32'd0, 3'd0, 32'd0, 1'b1, 3'd5, 2'b00, "rsv5");
        idle("rsv5_n1");
        chk("busy_set5", {24'd0, busy}, 32'h20);
        cyc(1'b1, 2'b10, 3'd0, 32'd0, 3'd5, 32'h55, 1'b0, 3'd0, 2'b10, "clr5");
        idle("clr5_n1");
        chk("busy_clr5", {24'd0, busy}, 32'h00);

        // Same-cycle set and clear on one address: set wins.
        cyc(1'b1, 2'b00, 3'd0, 32'd0, 3'd0, 32'd0, 1'b1, 3'd5, 2'b00, "rsv5b");
        cyc(1'b1, 2'b01, 3'd5, 32'h66, 3'd0, 32'd0, 1'b1, 3'd5, 2'b01, "setclr5");
        idle("setclr5_n1");
        chk("busy_set_wins", {24'd0, busy}, 32'h20);
        cyc(1'b1, 2'b10, 3'd0, 32'd0, 3'd5, 32'h77, 1'b0, 3'd0, 2'b10, "clr5b");
        idle("clr5b_n1");
        chk("busy_clr5b", {24'd0, busy}, 32'h00);

        // Saturation: the previous grant went to req1, so the loop starts with req0.
        for (int i = 0; i < 65540; i++) begin
            g = (tie_b == 2'b01) ? 2'b01 : (i[0] ? 2'b10 : 2'b01);
            cyc(1'b1, 2'b11, 3'd6, 32'(i), 3'd7, ~32'(i), 1'b0, 3'd0, g, "sat");
        end
        idle("sat_n1");
        chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        idle("sat_n2");
        chk("stall_sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);

        // Reset mid-transfer drops the grant and clears the scoreboard.
        cyc(1'b1, 2'b00, 3'd0, 32'd0, 3'd0, 32'd0, 1'b1, 3'd4, 2'b00, "rsv4");
        idle("rsv4_n1");
        chk("busy_set4", {24'd0, busy}, 32'h10);
        cyc(1'b0, 2'b01, 3'd2, 32'h99, 3'd0, 32'd0, 1'b1, 3'd4, 2'b00, "mid_rst");
        idle("mid_rst_n1");
        chk("mid_rst_we", {31'd0, we}, 32'd0);
        chk("mid_rst_busy", {24'd0, busy}, 32'd0);
        chk("mid_rst_stall", {16'd0, stall_cnt}, 32'd0);
        chk("mid_rst_wa", {29'd0, wa}, 32'd0);

        // After reset requester 0 wins the first tie in both builds.
        cyc(1'b1, 2'b11, 3'd1, 32'hC1, 3'd2, 32'hC2, 1'b0, 3'd0, 2'b01, "post_rst_tie");
        idle("post_rst_n1");
        idle("post_rst_n2");
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
